// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage. One op in flight;
// shift-add multiply and restoring divide take 32 cycles, divide corner cases take one.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write_out
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [2:0]        op;
    logic [4:0]        rd_q;
    logic [4:0]        count;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic              neg_q;
    logic              neg_r;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     rem;

    logic              accept;
    logic              is_div;
    logic              sign_a;
    logic              sign_b;
    logic              a_neg;
    logic              b_neg;
    logic              div_by_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   a_in;
    logic [XLEN-1:0]   b_in;
    logic [XLEN-1:0]   special_res;

    assign accept      = (state == S_IDLE) && start && !flush;
    assign is_div      = funct3[2];
    assign sign_a      = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                         (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sign_b      = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg       = sign_a && rs1_val[XLEN-1];
    assign b_neg       = sign_b && rs2_val[XLEN-1];
    assign a_in        = a_neg ? -rs1_val : rs1_val;
    assign b_in        = b_neg ? -rs2_val : rs2_val;
    assign div_by_zero = is_div && (rs2_val == '0);
    assign div_ovf     = is_div && !funct3[0] && (rs1_val == MIN_INT) && (rs2_val == '1);
    assign special     = div_by_zero || div_ovf;

    // funct3[1] separates REM/REMU from DIV/DIVU among the divide ops
    always_comb begin
        special_res = '0;
        if (funct3[1]) begin
            special_res = div_by_zero ? rs1_val : '0;
        end else begin
            special_res = div_by_zero ? '1 : MIN_INT;
        end
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN+1:0]   div_shift;
    logic [XLEN+1:0]   div_diff;
    logic              div_ok;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    // Multiply keeps the multiplier in acc's low half and shifts the product in from the top;
    // divide keeps the dividend in acc's low half and shifts quotient bits in from the bottom.
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_abs} : '0);
    assign mul_next  = {mul_sum, acc[XLEN-1:1]};
    assign div_shift = {rem, acc[XLEN-1]};
    assign div_diff  = div_shift - {2'b00, b_abs};
    assign div_ok    = ~div_diff[XLEN+1];
    assign rem_next  = div_ok ? div_diff[XLEN:0] : div_shift[XLEN:0];
    assign quo_next  = {acc[XLEN-2:0], div_ok};
    assign prod      = neg_q ? -mul_next : mul_next;
    assign quo_fix   = neg_q ? -quo_next : quo_next;
    assign rem_fix   = neg_r ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];

    always_comb begin
        final_res = '0;
        case (op)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op     <= '0;
            rd_q   <= '0;
            count  <= '0;
            a_abs  <= '0;
            b_abs  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            rem    <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op    <= funct3;
                        rd_q  <= rd_in;
                        a_abs <= a_in;
                        b_abs <= b_in;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        count <= '0;
                        rem   <= '0;
                        acc   <= is_div ? {{XLEN{1'b0}}, a_in} : {{XLEN{1'b0}}, b_in};
                        if (special) begin
                            state  <= S_DONE;
                            result <= special_res;
                            rd_out <= rd_in;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        count <= count + 5'd1;
                        acc   <= op[2] ? {{XLEN{1'b0}}, quo_next} : mul_next;
                        rem   <= op[2] ? rem_next : rem;
                        if (count == 5'd31) begin
                            state  <= S_DONE;
                            result <= final_res;
                            rd_out <= rd_q;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // stall drops in DONE so the EX->WB register captures the result on that edge
    assign stall         = accept || (state == S_CALC);
    assign done          = (state == S_DONE);
    assign reg_write_out = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: expected results are queued when an op is
// issued and popped when done pulses; latency and stall length are checked alongside.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        reg_write_out;

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [31:0] exp_res_q[$];
    logic [4:0]  exp_rd_q[$];

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .funct3(funct3),
        .rs1_val(rs1_val),
        .rs2_val(rs2_val),
        .rd_in(rd_in),
        .flush(flush),
        .stall(stall),
        .done(done),
        .result(result),
        .rd_out(rd_out),
        .reg_write_out(reg_write_out)
    );

    always #5 clk = ~clk;

    // Reference RV32M semantics, written directly from the ISA definition
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        r  = '0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a
                      : 32'($signed(a) / $signed(b)));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0
                      : 32'($signed(a) % $signed(b)));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
        start   = 1'b1;
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        exp_res_q.push_back(exp);
        exp_rd_q.push_back(rd);
        #1;
    endtask

    // Waits (bounded) for done; lat counts negedges from the issue cycle, stall_cnt counts stall cycles
    task automatic wait_done(input bit hold_start, output int lat, output int stall_cnt,
                             output logic [31:0] res, output logic [4:0] rdo, output logic wr);
        bit got;
        lat = 0;
        stall_cnt = (stall === 1'b1) ? 1 : 0;
        res = '0;
        rdo = '0;
        wr  = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                got = 1'b1;
                res = result;
                rdo = rd_out;
                wr  = reg_write_out;
            end else if (stall === 1'b1) begin
                stall_cnt++;
            end
            if (!hold_start) start = 1'b0;
            if (got) break;
        end
        if (!hold_start) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
        rs1_val = '0; rs2_val = '0; rd_in = '0;
        repeat (2) @(negedge clk);
        n_vectors++; if (done !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
        n_vectors++; if (stall !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
        n_vectors++; if (result !== 32'd0) begin n_miscompares++; $display("[TB] FAIL reset_result got %h want 0", result); end
        n_vectors++; if (rd_out !== 5'd0) begin n_miscompares++; $display("[TB] FAIL reset_rd_out got %0d want 0", rd_out); end
        n_vectors++; if (reg_write_out !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset_wr got %b want 0", reg_write_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_table(input string tag, input vec_t tbl[$]);
        int lat, sc;
        logic [31:0] res, e_res;
        logic [4:0]  rdo, e_rd;
        logic        wr;
        foreach (tbl[i]) begin
            issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp);
            wait_done(1'b0, lat, sc, res, rdo, wr);
            e_res = exp_res_q.pop_front();
            e_rd  = exp_rd_q.pop_front();
            n_vectors++; if (res !== e_res) begin n_miscompares++; $display("[TB] FAIL %s[%0d] result got %h want %h", tag, i, res, e_res); end
            n_vectors++; if (rdo !== e_rd) begin n_miscompares++; $display("[TB] FAIL %s[%0d] rd_out got %0d want %0d", tag, i, rdo, e_rd); end
            n_vectors++; if (wr !== (e_rd != 0)) begin n_miscompares++; $display("[TB] FAIL %s[%0d] reg_write got %b want %b", tag, i, wr, e_rd != 0); end
            n_vectors++; if (lat != tbl[i].lat) begin n_miscompares++; $display("[TB] FAIL %s[%0d] latency got %0d want %0d", tag, i, lat, tbl[i].lat); end
            n_vectors++; if (sc != tbl[i].lat) begin n_miscompares++; $display("[TB] FAIL %s[%0d] stall_cycles got %0d want %0d", tag, i, sc, tbl[i].lat); end
        end
    endtask

    task automatic test_mul_div;
        vec_t tbl[$];
        tbl = '{
            '{3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         33},
            '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  33},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  33},
            '{3'd2, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,  33},
            '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  33},
            '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd31, 32'hFFFF_FFFF,  33},
            '{3'd5, 32'd100,        32'd7,          5'd6,  32'd14,         33},
            '{3'd7, 32'd100,        32'd7,          5'd7,  32'd2,          33}
        };
        run_table("muldiv", tbl);
    endtask

    task automatic test_div_special;
        vec_t tbl[$];
        tbl = '{
            '{3'd4, 32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF,  1},
            '{3'd6, 32'd5,          32'd0,          5'd9,  32'd5,          1},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  1},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          1}
        };
        run_table("special", tbl);
    endtask

    task automatic test_random;
        vec_t tbl[$];
        vec_t v;
        for (int i = 0; i < 8; i++) begin
            v.f  = (i == 4) ? 3'd7 : 3'($urandom_range(0, 7));
            v.a  = $urandom();
            v.b  = (i == 4) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 1000)) : $urandom());
            v.rd = 5'($urandom_range(0, 31));
            v.exp = model(v.f, v.a, v.b);
            v.lat = model_lat(v.f, v.a, v.b);
            tbl.push_back(v);
        end
        run_table("random", tbl);
    endtask

    task automatic test_back_to_back;
        int lat, sc;
        logic [31:0] res, e_res;
        logic [4:0]  rdo, e_rd;
        logic        wr;
        issue(3'd0, 32'd7, 32'd6, 5'd5, 32'd42);
        wait_done(1'b1, lat, sc, res, rdo, wr);
        e_res = exp_res_q.pop_front(); e_rd = exp_rd_q.pop_front();
        n_vectors++; if (res !== e_res) begin n_miscompares++; $display("[TB] FAIL b2b_first result got %h want %h", res, e_res); end
        n_vectors++; if (lat != 33) begin n_miscompares++; $display("[TB] FAIL b2b_first latency got %0d want 33", lat); end
        // start stays high through DONE; the DIV must only be taken in the following IDLE cycle
        issue(3'd5, 32'd100, 32'd7, 5'd9, 32'd14);
        wait_done(1'b1, lat, sc, res, rdo, wr);
        start = 1'b0;
        e_res = exp_res_q.pop_front(); e_rd = exp_rd_q.pop_front();
        n_vectors++; if (res !== e_res) begin n_miscompares++; $display("[TB] FAIL b2b_second result got %h want %h", res, e_res); end
        n_vectors++; if (rdo !== e_rd) begin n_miscompares++; $display("[TB] FAIL b2b_second rd_out got %0d want %0d", rdo, e_rd); end
        n_vectors++; if (lat != 34) begin n_miscompares++; $display("[TB] FAIL b2b_second latency got %0d want 34", lat); end
        n_vectors++; if (sc != 33) begin n_miscompares++; $display("[TB] FAIL b2b_second stall_cycles got %0d want 33", sc); end
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd3, 5'd0, 32'd9);
        wait_done(1'b0, lat, sc, res, rdo, wr);
        e_res = exp_res_q.pop_front(); e_rd = exp_rd_q.pop_front();
        n_vectors++; if (res !== e_res) begin n_miscompares++; $display("[TB] FAIL rd0 result got %h want %h", res, e_res); end
        n_vectors++; if (lat != 33) begin n_miscompares++; $display("[TB] FAIL rd0 latency got %0d want 33", lat); end
        n_vectors++; if (wr !== 1'b0) begin n_miscompares++; $display("[TB] FAIL rd0 reg_write got %b want 0", wr); end
    endtask

    task automatic test_flush;
        int pulses;
        logic [31:0] d_res;
        logic [4:0]  d_rd;
        issue(3'd0, 32'd123, 32'd456, 5'd7, 32'd56088);
        d_res = exp_res_q.pop_front(); d_rd = exp_rd_q.pop_front();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vectors++; if (stall !== 1'b0) begin n_miscompares++; $display("[TB] FAIL flush_stall got %b want 0", stall); end
        n_vectors++; if (done !== 1'b0) begin n_miscompares++; $display("[TB] FAIL flush_done got %b want 0", done); end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_vectors++; if (pulses != 0) begin n_miscompares++; $display("[TB] FAIL flush_no_done got %0d pulses want 0", pulses); end
    endtask

    task automatic test_reset_mid_op;
        int lat, sc;
        logic [31:0] res, e_res;
        logic [4:0]  rdo, e_rd;
        logic        wr;
        issue(3'd7, 32'd100, 32'd7, 5'd12, 32'd2);
        wait_done(1'b0, lat, sc, res, rdo, wr);
        e_res = exp_res_q.pop_front(); e_rd = exp_rd_q.pop_front();
        n_vectors++; if (res !== e_res) begin n_miscompares++; $display("[TB] FAIL pre_reset result got %h want %h", res, e_res); end
        issue(3'd0, 32'd5, 32'd5, 5'd3, 32'd25);
        e_res = exp_res_q.pop_front(); e_rd = exp_rd_q.pop_front();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_vectors++; if (stall !== 1'b0) begin n_miscompares++; $display("[TB] FAIL midrst_stall got %b want 0", stall); end
        n_vectors++; if (done !== 1'b0) begin n_miscompares++; $display("[TB] FAIL midrst_done got %b want 0", done); end
        n_vectors++; if (result !== 32'd0) begin n_miscompares++; $display("[TB] FAIL midrst_result got %h want 0", result); end
        n_vectors++; if (rd_out !== 5'd0) begin n_miscompares++; $display("[TB] FAIL midrst_rd_out got %0d want 0", rd_out); end
        n_vectors++; if (reg_write_out !== 1'b0) begin n_miscompares++; $display("[TB] FAIL midrst_wr got %b want 0", reg_write_out); end
        @(negedge clk);
        rst = 1'b0;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
        wait_done(1'b0, lat, sc, res, rdo, wr);
        e_res = exp_res_q.pop_front(); e_rd = exp_rd_q.pop_front();
        n_vectors++; if (res !== e_res) begin n_miscompares++; $display("[TB] FAIL post_reset result got %h want %h", res, e_res); end
        n_vectors++; if (rdo !== e_rd) begin n_miscompares++; $display("[TB] FAIL post_reset rd_out got %0d want %0d", rdo, e_rd); end
        n_vectors++; if (lat != 33) begin n_miscompares++; $display("[TB] FAIL post_reset latency got %0d want 33", lat); end
    endtask

    initial begin
        test_reset();
        test_mul_div();
        test_div_special();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
